// File: rtl/mult_result_serializer_if.sv
// Stream bundle for mult_result_serializer: product input and word output.
// slave = serializer side, master = multiplier/consumer side.
interface mult_result_serializer_if #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32
);
    localparam int NW    = DATA_W / WORD_W;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_idx,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_idx,
        input  out_last
    );
endinterface

// File: rtl/mult_result_serializer.sv
// Buffers 128-bit multiplier products in a small FIFO and streams them out
// LSW first as 32-bit words; ports: clk, rst_n, bus (stream), drop_err/drop_cnt.
module mult_result_serializer #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mult_result_serializer_if.slave bus,
    output logic                   drop_err,
    output logic [7:0]             drop_cnt
);
    localparam int NW    = DATA_W / WORD_W;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             drop_err_q, drop_err_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              drop;
    logic              xfer;
    logic              pop;
    logic [DATA_W-1:0] head;

    // Ready/valid come only from registered occupancy; a pop at full
    // cannot make room for a product arriving in the same cycle.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);

    assign push = bus.in_valid && in_ready;
    assign drop = bus.in_valid && !in_ready;
    assign xfer = out_valid && bus.out_ready;
    assign pop  = xfer && (idx_q == LAST_IDX);

    // When empty this still shows the stale head word.
    assign head = mem_q[rd_ptr_q];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head[idx_q*WORD_W +: WORD_W];
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = out_valid && (idx_q == LAST_IDX);

    assign drop_err = drop_err_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        drop_err_d = drop;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (xfer) begin
            if (idx_q == LAST_IDX) begin
                idx_d    = '0;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            drop_err_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            drop_err_q <= drop_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end
endmodule

// File: doc/mult_result_serializer.md
# mult_result_serializer

Output-side companion to the 4-input 32-bit pipelined multiplier (`pipeline_multi_4in_32bit`). It accepts the 128-bit product `g_outM`, stores it in a small FIFO, and returns it as four 32-bit words, least-significant word first, over a valid/ready stream. It absorbs downstream back-pressure. Because the multiplier cannot stall, the block flags and counts any product it has to drop.

## Interface
Parameters:
- `DATA_W`, 128, product width; must be a multiple of `WORD_W`
- `WORD_W`, 32, output word width
- `DEPTH`, 2, FIFO entries (each `DATA_W` bits); power of two, ≥ 2

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  a product is presented on `in_data` this cycle
- `in_data`  in  `DATA_W`  product from multiplier (`g_outM`)
- `in_ready`  out  1  FIFO can accept an entry this cycle
- `out_valid`  out  1  `out_data` holds a valid word
- `out_ready`  in  1  downstream accepts word this cycle
- `out_data`  out  `WORD_W`  current word of head entry
- `out_idx`  out  log2(`DATA_W`/`WORD_W`)  index of current word (0 = LSW)
- `out_last`  out  1  current word is the MSW of its product
- `drop_err`  out  1  one-cycle pulse: a product was dropped
- `drop_cnt`  out  8  saturating count of dropped products

## Operation
- NW = `DATA_W`/`WORD_W` (4 at defaults).
- **FIFO state:**
  - write pointer, read pointer, occupancy `count` (0..`DEPTH`);
  - word counter `idx` (0..NW-1).
- **Push:** `in_valid && in_ready`.
  - `in_data` is written at the write pointer.
  - The write pointer increments, wrapping modulo `DEPTH`.
- **Drop:** `in_valid && !in_ready`.
  - Data is discarded and the FIFO is unchanged.
  - `drop_err` = 1 on the next cycle.
  - `drop_cnt` increments, saturating at 255.
- `in_ready` = (`count` != `DEPTH`). It depends only on registered state, so there is no same-cycle pass-through when full.
- `out_valid` = (`count` != 0).
- `out_data` = head[`idx`·`WORD_W` +: `WORD_W`].
- `out_idx` = `idx`.
- `out_last` = `out_valid && idx == NW-1`.
- **Word transfer:** `out_valid && out_ready`.
  - If `idx` < NW-1: `idx` increments.
  - If `idx` == NW-1: `idx` goes to 0 and the entry is popped (read pointer increments and wraps).
- **Occupancy:**
  - push only: `count`+1;
  - pop only: `count`-1;
  - push and pop in the same cycle: `count` unchanged (legal at any `count` in 1..`DEPTH`-1).
- **Output stability:** while `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_idx` and `out_last` hold stable.
- **Full:** `in_ready` = 0. At full, a pop and an arriving product in the same cycle still causes a drop, because `in_ready` is evaluated before the pop.
- **Empty:**
  - `out_valid` = 0 and `out_ready` is ignored.
  - `out_data` is don't-care; the implementation drives the stale head word.
- **Reset (`rst_n` = 0, asynchronous, any time including mid-product):**
  - pointers, `count`, `idx`, `drop_err` and `drop_cnt` clear to 0;
  - a partially sent product is abandoned and never resumed;
  - FIFO storage is not cleared.
- **Outputs during reset:** `in_ready` = 1, `out_valid` = 0, `out_idx` = 0, `out_last` = 0, `drop_err` = 0, `drop_cnt` = 0, `out_data` = don't-care.

## Timing
- **Latency:** a product pushed at edge N gives `out_valid` = 1 with word 0 after edge N (visible in cycle N+1).
- **Throughput:** one word per cycle with `out_ready` held high, i.e. one product per NW cycles. Sustained input faster than 1 per NW cycles eventually drops.
- **Back-to-back products:** after the `out_last` transfer, the next entry's word 0 appears in the following cycle with no bubble.
- **Drop signalling:** `drop_err` is registered and asserts the cycle after the dropped `in_valid`.
- **Output paths:** all outputs come from registers or from a FIFO-read mux driven by registers. There is no combinational path from `out_ready` or `in_valid` to any output.

## Test plan
- **Single product:** reset, then push `in_data` = 16 (= 2·2·2·2), `out_ready` = 1 → words 16, 0, 0, 0 on 4 consecutive cycles; `out_idx` 0..3; `out_last` only on the 4th; then `out_valid` = 0.
- **Word ordering:** push 0x00000004_00000003_00000002_00000001 → `out_data` 1, 2, 3, 4.
- **Back-pressure:**
  - push 0xFFFF…F with `out_ready` = 0 for 5 cycles → `out_valid` = 1, `out_data` = 0xFFFFFFFF, `out_idx` = 0 held;
  - then raise `out_ready` → 4 words.
- **Full and drop:**
  - `out_ready` = 0; push A, B, C on consecutive cycles → `in_ready` = 0 after B;
  - C is dropped: `drop_err` pulses once and `drop_cnt` = 1;
  - draining yields A's 4 words then B's, never C.
- **Simultaneous push/pop:**
  - `count` = 1; push on the same cycle as the `out_last` transfer → `count` stays 1;
  - the next product's word 0 follows with no gap.
- **Reset mid-product:**
  - pulse `rst_n` low after 2 words sent (`drop_cnt` = 3 beforehand) → `out_valid` = 0, `drop_cnt` = 0;
  - a new push then starts at `out_idx` = 0.
